fpu_float_wb: RTL and testbench

- Consumer end of the float execution pipeline.
- Accepts stage-2 results from the float pipeline (valid/result/fflags/rd, no ready; back-pressure via stall), fdiv/fsqrt results and remote float-load responses (valid/yumi).
- Arbitrates them onto the single FP register-file write port, registered.
- Accumulates sticky fflags for fcsr and emits scoreboard-clear pulses for long-latency sources.

---
 rtl/bsg_vanilla_pkg.sv | 21 ++
 rtl/fpu_float_wb_arb.sv | 54 +++++
 rtl/fpu_float_wb.sv | 151 +++++++++++++++
 tb/tb_fpu_float_wb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the float writeback block.
//   fflags_s   : IEEE exception flags in fcsr bit order {nv,dz,of,uf,nx}
//   wb_src_e   : which source owns the FP regfile write port this cycle
package bsg_vanilla_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_s;

    typedef enum logic [1:0] {
        e_wb_none = 2'd0,
        e_wb_fp   = 2'd1,
        e_wb_fdiv = 2'd2,
        e_wb_rl   = 2'd3
    } wb_src_e;

endpackage

// File: rtl/fpu_float_wb_arb.sv
// Fixed-priority arbiter for the FP regfile write port, with a starvation
// counter that lets a waiting fdiv result overtake the float pipeline.
// Ports:
//   clk_i, reset_n_i            clock, async active-low reset
//   fp_v_i, fdiv_v_i, rl_v_i    request valids
//   grant_fp_o/fdiv_o/rl_o      one-hot grant (all 0 while in reset)
module fpu_float_wb_arb #(
    parameter int starve_limit_p = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic fp_v_i,
    input  logic fdiv_v_i,
    input  logic rl_v_i,
    output logic grant_fp_o,
    output logic grant_fdiv_o,
    output logic grant_rl_o
);

    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

    logic [cnt_width_lp-1:0] r_starve_cnt;
    logic                    w_starved;

    assign w_starved = (r_starve_cnt == limit_lp);

    // Grants are gated by reset so no handshake leaks out while reset is held.
    always_comb begin
        grant_fp_o   = 1'b0;
        grant_fdiv_o = 1'b0;
        grant_rl_o   = 1'b0;
        if (reset_n_i) begin
            if (rl_v_i)
                grant_rl_o = 1'b1;
            else if (fdiv_v_i && w_starved)
                grant_fdiv_o = 1'b1;
            else if (fp_v_i)
                grant_fp_o = 1'b1;
            else if (fdiv_v_i)
                grant_fdiv_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_starve_cnt <= '0;
        else if (grant_fdiv_o || !fdiv_v_i)
            r_starve_cnt <= '0;
        else if (!w_starved)
            r_starve_cnt <= r_starve_cnt + cnt_width_lp'(1);
    end

endmodule

// File: rtl/fpu_float_wb.sv
// Float writeback: arbitrates float-pipeline, fdiv/fsqrt and remote-load
// results onto the single FP regfile write port (registered), accumulates
// sticky fflags and issues scoreboard clears for long-latency sources.
// Ports:
//   fp_*        float pipeline stage-2 result; stall_fpu2_o holds it
//   fdiv_*      fdiv/fsqrt result, consumed by fdiv_yumi_o
//   rl_*        remote float-load response, consumed by rl_yumi_o
//   fcsr_*      CSR write into the sticky flags; fflags_o is the current value
//   frf_w_*     registered regfile write
//   sb_clear_*  registered scoreboard clear (fdiv and rl writes only)
module fpu_float_wb
    import bsg_vanilla_pkg::*;
#(
    parameter int recoded_data_width_p = 33,
    parameter int reg_addr_width_p     = 5,
    parameter int starve_limit_p       = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,

    input  logic                            fp_v_i,
    input  logic [recoded_data_width_p-1:0] fp_result_i,
    input  logic [4:0]                      fp_fflags_i,
    input  logic [reg_addr_width_p-1:0]     fp_rd_i,
    output logic                            stall_fpu2_o,

    input  logic                            fdiv_v_i,
    input  logic [recoded_data_width_p-1:0] fdiv_result_i,
    input  logic [4:0]                      fdiv_fflags_i,
    input  logic [reg_addr_width_p-1:0]     fdiv_rd_i,
    output logic                            fdiv_yumi_o,

    input  logic                            rl_v_i,
    input  logic [recoded_data_width_p-1:0] rl_data_i,
    input  logic [reg_addr_width_p-1:0]     rl_rd_i,
    output logic                            rl_yumi_o,

    input  logic                            fcsr_fflags_we_i,
    input  logic [4:0]                      fcsr_fflags_data_i,
    output logic [4:0]                      fflags_o,

    output logic                            frf_w_v_o,
    output logic [reg_addr_width_p-1:0]     frf_w_addr_o,
    output logic [recoded_data_width_p-1:0] frf_w_data_o,

    output logic                            sb_clear_v_o,
    output logic [reg_addr_width_p-1:0]     sb_clear_rd_o
);

    logic    w_grant_fp;
    logic    w_grant_fdiv;
    logic    w_grant_rl;
    wb_src_e w_src;

    logic [reg_addr_width_p-1:0]     w_addr;
    logic [recoded_data_width_p-1:0] w_data;
    fflags_s                         w_wb_flags;
    fflags_s                         w_fflags_base;
    logic                            w_clear;

    fflags_s                         r_fflags;
    logic                            r_frf_w_v;
    logic [reg_addr_width_p-1:0]     r_frf_w_addr;
    logic [recoded_data_width_p-1:0] r_frf_w_data;
    logic                            r_sb_clear_v;
    logic [reg_addr_width_p-1:0]     r_sb_clear_rd;

    fpu_float_wb_arb #(
        .starve_limit_p(starve_limit_p)
    ) arb (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .fp_v_i      (fp_v_i),
        .fdiv_v_i    (fdiv_v_i),
        .rl_v_i      (rl_v_i),
        .grant_fp_o  (w_grant_fp),
        .grant_fdiv_o(w_grant_fdiv),
        .grant_rl_o  (w_grant_rl)
    );

    assign stall_fpu2_o = fp_v_i & ~w_grant_fp & reset_n_i;
    assign fdiv_yumi_o  = w_grant_fdiv;
    assign rl_yumi_o    = w_grant_rl;

    always_comb begin
        w_src = e_wb_none;
        if (w_grant_rl)
            w_src = e_wb_rl;
        else if (w_grant_fdiv)
            w_src = e_wb_fdiv;
        else if (w_grant_fp)
            w_src = e_wb_fp;
    end

    // Loads carry no exception flags; only fdiv and loads are scoreboarded.
    always_comb begin
        w_addr     = '0;
        w_data     = '0;
        w_wb_flags = '0;
        w_clear    = 1'b0;
        case (w_src)
            e_wb_fp: begin
                w_addr     = fp_rd_i;
                w_data     = fp_result_i;
                w_wb_flags = fflags_s'(fp_fflags_i);
            end
            e_wb_fdiv: begin
                w_addr     = fdiv_rd_i;
                w_data     = fdiv_result_i;
                w_wb_flags = fflags_s'(fdiv_fflags_i);
                w_clear    = 1'b1;
            end
            e_wb_rl: begin
                w_addr  = rl_rd_i;
                w_data  = rl_data_i;
                w_clear = 1'b1;
            end
            default: ;
        endcase
    end

    // A CSR write replaces the old flags but still picks up flags from the
    // result retiring in the same cycle.
    assign w_fflags_base = fcsr_fflags_we_i ? fflags_s'(fcsr_fflags_data_i) : r_fflags;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fflags      <= '0;
            r_frf_w_v     <= 1'b0;
            r_frf_w_addr  <= '0;
            r_frf_w_data  <= '0;
            r_sb_clear_v  <= 1'b0;
            r_sb_clear_rd <= '0;
        end else begin
            r_fflags      <= w_fflags_base | w_wb_flags;
            r_frf_w_v     <= (w_src != e_wb_none);
            r_frf_w_addr  <= w_addr;
            r_frf_w_data  <= w_data;
            r_sb_clear_v  <= w_clear;
            r_sb_clear_rd <= w_clear ? w_addr : '0;
        end
    end

    assign fflags_o      = r_fflags;
    assign frf_w_v_o     = r_frf_w_v;
    assign frf_w_addr_o  = r_frf_w_addr;
    assign frf_w_data_o  = r_frf_w_data;
    assign sb_clear_v_o  = r_sb_clear_v;
    assign sb_clear_rd_o = r_sb_clear_rd;

endmodule

// File: tb/tb_fpu_float_wb.sv
// Directed bench for fpu_float_wb: priority, latency, starvation override,
// fflags accumulation, async reset and idle behaviour.
module tb_fpu_float_wb;

    logic        clk_i;
    logic        reset_n_i;
    logic        fp_v_i;
    logic [32:0] fp_result_i;
    logic [4:0]  fp_fflags_i;
    logic [4:0]  fp_rd_i;
    logic        stall_fpu2_o;
    logic        fdiv_v_i;
    logic [32:0] fdiv_result_i;
    logic [4:0]  fdiv_fflags_i;
    logic [4:0]  fdiv_rd_i;
    logic        fdiv_yumi_o;
    logic        rl_v_i;
    logic [32:0] rl_data_i;
    logic [4:0]  rl_rd_i;
    logic        rl_yumi_o;
    logic        fcsr_fflags_we_i;
    logic [4:0]  fcsr_fflags_data_i;
    logic [4:0]  fflags_o;
    logic        frf_w_v_o;
    logic [4:0]  frf_w_addr_o;
    logic [32:0] frf_w_data_o;
    logic        sb_clear_v_o;
    logic [4:0]  sb_clear_rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_float_wb #(
        .recoded_data_width_p(33),
        .reg_addr_width_p    (5),
        .starve_limit_p      (8)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .fp_v_i            (fp_v_i),
        .fp_result_i       (fp_result_i),
        .fp_fflags_i       (fp_fflags_i),
        .fp_rd_i           (fp_rd_i),
        .stall_fpu2_o      (stall_fpu2_o),
        .fdiv_v_i          (fdiv_v_i),
        .fdiv_result_i     (fdiv_result_i),
        .fdiv_fflags_i     (fdiv_fflags_i),
        .fdiv_rd_i         (fdiv_rd_i),
        .fdiv_yumi_o       (fdiv_yumi_o),
        .rl_v_i            (rl_v_i),
        .rl_data_i         (rl_data_i),
        .rl_rd_i           (rl_rd_i),
        .rl_yumi_o         (rl_yumi_o),
        .fcsr_fflags_we_i  (fcsr_fflags_we_i),
        .fcsr_fflags_data_i(fcsr_fflags_data_i),
        .fflags_o          (fflags_o),
        .frf_w_v_o         (frf_w_v_o),
        .frf_w_addr_o      (frf_w_addr_o),
        .frf_w_data_o      (frf_w_data_o),
        .sb_clear_v_o      (sb_clear_v_o),
        .sb_clear_rd_o     (sb_clear_rd_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n_i          = 1'b0;
        fp_v_i             = 1'b0;
        fp_result_i        = '0;
        fp_fflags_i        = '0;
        fp_rd_i            = '0;
        fdiv_v_i           = 1'b0;
        fdiv_result_i      = '0;
        fdiv_fflags_i      = '0;
        fdiv_rd_i          = '0;
        rl_v_i             = 1'b0;
        rl_data_i          = '0;
        rl_rd_i            = '0;
        fcsr_fflags_we_i   = 1'b0;
        fcsr_fflags_data_i = '0;
        repeat (2) tick();

        check_val("rst_frf_v",  64'(frf_w_v_o), 64'd0);
        check_val("rst_addr",   64'(frf_w_addr_o), 64'd0);
        check_val("rst_sb_v",   64'(sb_clear_v_o), 64'd0);
        check_val("rst_fflags", 64'(fflags_o), 64'd0);

        // 1: first fp result after reset release
        fp_v_i      = 1'b1;
        fp_rd_i     = 5'd3;
        fp_result_i = 33'h0_8000_0000;
        fp_fflags_i = 5'b00001;
        #1;
        check_val("rst_stall_gated", 64'(stall_fpu2_o), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        check_val("t1_stall", 64'(stall_fpu2_o), 64'd0);
        tick();
        check_val("t1_frf_v",   64'(frf_w_v_o), 64'd1);
        check_val("t1_addr",    64'(frf_w_addr_o), 64'd3);
        check_val("t1_data",    64'(frf_w_data_o), 64'h0_8000_0000);
        check_val("t1_fflags",  64'(fflags_o), 64'b00001);
        check_val("t1_sb_v",    64'(sb_clear_v_o), 64'd0);
        fp_v_i = 1'b0;
        tick();
        check_val("t1_pulse", 64'(frf_w_v_o), 64'd0);

        // 2: remote load beats the float pipeline
        rl_v_i      = 1'b1;
        rl_rd_i     = 5'd7;
        rl_data_i   = 33'h1_2345_6789;
        fp_v_i      = 1'b1;
        fp_rd_i     = 5'd4;
        fp_result_i = 33'h0_0000_0004;
        fp_fflags_i = 5'b00000;
        #1;
        check_val("t2_rl_yumi",   64'(rl_yumi_o), 64'd1);
        check_val("t2_stall",     64'(stall_fpu2_o), 64'd1);
        check_val("t2_fdiv_yumi", 64'(fdiv_yumi_o), 64'd0);
        tick();
        check_val("t2_rl_v",     64'(frf_w_v_o), 64'd1);
        check_val("t2_rl_addr",  64'(frf_w_addr_o), 64'd7);
        check_val("t2_rl_data",  64'(frf_w_data_o), 64'h1_2345_6789);
        check_val("t2_sb_v",     64'(sb_clear_v_o), 64'd1);
        check_val("t2_sb_rd",    64'(sb_clear_rd_o), 64'd7);
        rl_v_i = 1'b0;
        #1;
        check_val("t2_unstall", 64'(stall_fpu2_o), 64'd0);
        tick();
        check_val("t2_fp_v",    64'(frf_w_v_o), 64'd1);
        check_val("t2_fp_addr", 64'(frf_w_addr_o), 64'd4);
        check_val("t2_fp_sb_v", 64'(sb_clear_v_o), 64'd0);
        check_val("t2_fflags",  64'(fflags_o), 64'b00001);
        fp_v_i = 1'b0;
        tick();

        // 3: fdiv starved by a busy float pipeline for 8 cycles
        fdiv_v_i      = 1'b1;
        fdiv_rd_i     = 5'd9;
        fdiv_result_i = 33'h0_3F80_0000;
        fdiv_fflags_i = 5'b01000;
        fp_v_i        = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fp_rd_i = 5'(i + 16);
            #1;
            check_val($sformatf("t3_deny_yumi_%0d", i), 64'(fdiv_yumi_o), 64'd0);
            check_val($sformatf("t3_deny_stall_%0d", i), 64'(stall_fpu2_o), 64'd0);
            tick();
            check_val($sformatf("t3_fp_addr_%0d", i), 64'(frf_w_addr_o), 64'(i + 16));
        end
        #1;
        check_val("t3_fdiv_yumi", 64'(fdiv_yumi_o), 64'd1);
        check_val("t3_fp_stall",  64'(stall_fpu2_o), 64'd1);
        tick();
        check_val("t3_fdiv_addr", 64'(frf_w_addr_o), 64'd9);
        check_val("t3_fdiv_data", 64'(frf_w_data_o), 64'h0_3F80_0000);
        check_val("t3_sb_v",      64'(sb_clear_v_o), 64'd1);
        check_val("t3_sb_rd",     64'(sb_clear_rd_o), 64'd9);
        check_val("t3_fflags",    64'(fflags_o), 64'b01001);
        fdiv_v_i = 1'b0;
        #1;
        check_val("t3_unstall", 64'(stall_fpu2_o), 64'd0);
        tick();
        check_val("t3_held_fp_addr", 64'(frf_w_addr_o), 64'd23);
        check_val("t3_held_fp_sb",   64'(sb_clear_v_o), 64'd0);
        fdiv_v_i = 1'b1;
        #1;
        check_val("t3_cnt_cleared", 64'(fdiv_yumi_o), 64'd0);
        tick();
        fdiv_v_i = 1'b0;
        fp_v_i   = 1'b0;
        tick();

        // 4: CSR write coinciding with a retiring fp result
        fcsr_fflags_we_i   = 1'b1;
        fcsr_fflags_data_i = 5'b10000;
        tick();
        check_val("t4_csr_set", 64'(fflags_o), 64'b10000);
        fcsr_fflags_data_i = 5'b00000;
        fp_v_i      = 1'b1;
        fp_rd_i     = 5'd2;
        fp_fflags_i = 5'b00100;
        tick();
        check_val("t4_csr_merge", 64'(fflags_o), 64'b00100);
        fcsr_fflags_we_i = 1'b0;
        fp_v_i           = 1'b0;
        fp_fflags_i      = 5'b00000;
        tick();

        // 5: async reset while a load is being granted
        rl_v_i    = 1'b1;
        rl_rd_i   = 5'd11;
        rl_data_i = 33'h0_0000_0011;
        tick();
        check_val("t5_pre_v", 64'(frf_w_v_o), 64'd1);
        rl_rd_i  = 5'd12;
        fp_v_i   = 1'b1;
        fdiv_v_i = 1'b1;
        #1;
        check_val("t5_pre_yumi", 64'(rl_yumi_o), 64'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_val("t5_rl_yumi",   64'(rl_yumi_o), 64'd0);
        check_val("t5_stall",     64'(stall_fpu2_o), 64'd0);
        check_val("t5_fdiv_yumi", 64'(fdiv_yumi_o), 64'd0);
        check_val("t5_frf_v",     64'(frf_w_v_o), 64'd0);
        check_val("t5_addr",      64'(frf_w_addr_o), 64'd0);
        check_val("t5_sb_v",      64'(sb_clear_v_o), 64'd0);
        check_val("t5_fflags",    64'(fflags_o), 64'd0);
        @(posedge clk_i);
        rl_v_i   = 1'b0;
        fp_v_i   = 1'b0;
        fdiv_v_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        check_val("t5_post_v1", 64'(frf_w_v_o), 64'd0);
        check_val("t5_post_sb", 64'(sb_clear_v_o), 64'd0);
        tick();
        check_val("t5_post_v2", 64'(frf_w_v_o), 64'd0);

        // 6: idle for 20 cycles with non-zero sticky flags
        fcsr_fflags_we_i   = 1'b1;
        fcsr_fflags_data_i = 5'b00110;
        tick();
        fcsr_fflags_we_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val($sformatf("t6_idle_v_%0d", i), 64'(frf_w_v_o), 64'd0);
            check_val($sformatf("t6_idle_fflags_%0d", i), 64'(fflags_o), 64'b00110);
        end
        fdiv_v_i = 1'b1;
        fp_v_i   = 1'b1;
        #1;
        check_val("t6_cnt_zero", 64'(fdiv_yumi_o), 64'd0);
        check_val("t6_fp_wins",  64'(stall_fpu2_o), 64'd0);
        tick();
        fdiv_v_i = 1'b0;
        fp_v_i   = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
